cg_enable_ctrl: RTL and testbench
=================================

# cg_enable_ctrl

Activity-based clock-gate enable controller. Runs on the free-running clock and produces the registered enable that drives the integrated clock gating cell in front of a gateable domain. It gates the domain after a programmable run of idle cycles and ungates it on a wake request. It holds off acknowledging the request until the ungated clock has settled, and keeps a saturating count of gated cycles for power statistics.

## Interface
- IDLE_CYCLES, 16: consecutive idle cycles required before gating; legal range 1..2**CNT_W-1.
- WAKE_CYCLES, 2: settle cycles between ungating and ack; legal range 1..2**CNT_W-1.
- CNT_W, 8: width of the internal idle/wake counter.
- ACTIVE_VALUE, 0: ICG polarity. 0 means en=1 passes the clock; 1 means en=0 passes the clock.
- STAT_W, 16: width of the gated-cycle statistic.
- clk_in  in  1  free-running (ungated) clock; all logic is on its rising edge.
- rst  in  1  synchronous reset, active-high.
- busy  in  1  activity from the gated domain; only meaningful while the clock is on.
- req  in  1  wake/keep-alive request, level; held until ack is seen.
- force_on  in  1  debug override; keeps the clock on and wakes the domain; never produces ack by itself.
- en  out  1  registered enable to the ICG, polarity per ACTIVE_VALUE.
- clk_on  out  1  status: 1 when the gated clock is running.
- ack  out  1  single-cycle request acknowledge.
- gated_cycles  out  STAT_W  saturating count of cycles spent in OFF.

## Operation
- States: ON, OFF, WAKE.
- Reset behaviour:
  - state=ON, counter=0, clk_on=1, ack=0, gated_cycles=0.
  - en=1 if ACTIVE_VALUE=0, else en=0.
- All outputs are registered. en always equals (ACTIVE_VALUE ? ~clk_on : clk_on).
- A cycle is *active* when busy|req|force_on.
- ON:
  - Counter clears on every active cycle and increments on every idle cycle.
  - An idle cycle with counter==IDLE_CYCLES-1 moves the block to OFF.
  - If req & ~ack: ack=1 next cycle, which gives one ack per request.
- OFF:
  - busy is ignored.
  - gated_cycles increments each cycle and saturates at all-ones.
  - req|force_on moves the block to WAKE with counter=0.
- WAKE:
  - clk_on=1 from the first WAKE cycle.
  - Counter increments each cycle.
  - When counter==WAKE_CYCLES-1, the block moves to ON and ack=1 in the first ON cycle, but only if req is still high.
  - req dropped during WAKE means no ack.
- Boundary conditions:
  - Activity on the final idle cycle counts as activity; no transition.
  - req and force_on together behave as req.
  - busy during WAKE is ignored; the ON counter starts from 0.
  - rst in any state, including mid-WAKE, returns to ON with clk_on=1 the next cycle and discards any pending ack.
  - gated_cycles never wraps.
- Requester rule: req must drop the cycle after ack.

## Timing
- Gating latency: with busy falling after cycle N, idle cycles are N+1..N+IDLE_CYCLES. clk_on=0 from N+IDLE_CYCLES+1.
- Wake latency: req seen in OFF at cycle M gives clk_on=1 at M+1 and ack at M+1+WAKE_CYCLES.
- Ack in ON: req rising at cycle K gives ack at K+1.
- en changes only just after a rising edge of clk_in, so it is stable through the ICG's transparent low phase. No combinational path runs from inputs to en.
- Minimum OFF dwell is one cycle.

## Structure
- Shared package cg_pkg holds:
  - typedef enum logic [1:0] cg_state_e {CG_ON, CG_OFF, CG_WAKE};
  - the localparam for the default IDLE_CYCLES.
- No sub-module. One state register, one CNT_W counter shared by ON and WAKE, and one saturating STAT_W counter.
- Instantiated beside the ICG cell with the same ACTIVE_VALUE.

## Test plan
- Reset, ACTIVE_VALUE=0: hold rst 2 cycles -> clk_on=1, en=1, ack=0, gated_cycles=0. Repeat with ACTIVE_VALUE=1 -> en=0.
- Idle gating, IDLE_CYCLES=16: busy=1 then 0 at cycle 10 -> clk_on=0 at cycle 27, gated_cycles counts 1,2,3…. A busy pulse at idle cycle 15 restarts the count and there is no gating.
- Wake, WAKE_CYCLES=2: from OFF, req=1 at cycle M -> clk_on=1 at M+1, ack pulse at M+3 only. Requester drops req at M+4; no second ack.
- force_on: in OFF with force_on=1 and req=0 -> wakes, no ack, and stays ON while force_on is held regardless of busy.
- Reset in WAKE: rst at WAKE cycle 1 -> ON next cycle, no ack, gated_cycles=0.
- Saturation, STAT_W=4: hold OFF 20 cycles -> gated_cycles sticks at 15.

Source files
------------

// File: rtl/cg_pkg.sv
// Shared definitions for the clock-gate enable controller.
//   cg_state_e          : controller states (clock running, gated, waking up)
//   IDLE_CYCLES_DEFAULT : default number of idle cycles before gating
package cg_pkg;

  typedef enum logic [1:0] {
    CG_ON   = 2'd0,
    CG_OFF  = 2'd1,
    CG_WAKE = 2'd2
  } cg_state_e;

  localparam int unsigned IDLE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/cg_enable_ctrl.sv
// Activity-based clock-gate enable controller.
// Runs on the free-running clock and drives the enable of the ICG cell in
// front of a gateable domain. The domain is gated after IDLE_CYCLES idle
// cycles, ungated on req/force_on, and req is acknowledged only after
// WAKE_CYCLES settle cycles. Cycles spent gated are counted (saturating).
//
// Ports:
//   clk_in       in   free-running clock, rising edge
//   rst          in   synchronous reset, active-high
//   busy         in   activity from the gated domain (ignored while gated)
//   req          in   wake/keep-alive request, level, held until ack
//   force_on     in   debug override, keeps the clock on, never acks
//   en           out  registered ICG enable, polarity per ACTIVE_VALUE
//   clk_on       out  1 while the gated clock is running
//   ack          out  single-cycle request acknowledge
//   gated_cycles out  saturating count of cycles spent gated
module cg_enable_ctrl
  import cg_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES  = IDLE_CYCLES_DEFAULT,
  parameter int unsigned WAKE_CYCLES  = 2,
  parameter int unsigned CNT_W        = 8,
  parameter bit          ACTIVE_VALUE = 1'b0,
  parameter int unsigned STAT_W       = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              busy,
  input  logic              req,
  input  logic              force_on,
  output logic              en,
  output logic              clk_on,
  output logic              ack,
  output logic [STAT_W-1:0] gated_cycles
);

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  cg_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              clk_on_q, clk_on_d;
  logic              ack_q, ack_d;
  logic              en_q, en_d;
  logic [STAT_W-1:0] gated_q, gated_d;

  logic active;
  assign active = busy | req | force_on;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clk_on_d = clk_on_q;
    ack_d    = 1'b0;
    gated_d  = gated_q;

    unique case (state_q)
      CG_ON: begin
        clk_on_d = 1'b1;
        // One ack per request: a req still high in the ack cycle is not
        // acknowledged again.
        ack_d    = req & ~ack_q;
        if (active) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d  = CG_OFF;
          cnt_d    = '0;
          clk_on_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      CG_OFF: begin
        clk_on_d = 1'b0;
        if (gated_q != '1) begin
          gated_d = gated_q + STAT_ONE;
        end
        if (req | force_on) begin
          state_d  = CG_WAKE;
          cnt_d    = '0;
          clk_on_d = 1'b1;
        end
      end

      CG_WAKE: begin
        clk_on_d = 1'b1;
        if (cnt_q == WAKE_LAST) begin
          // Counter restarts so the ON idle count begins from zero;
          // busy seen during WAKE has no effect on it.
          state_d = CG_ON;
          cnt_d   = '0;
          ack_d   = req;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d  = CG_ON;
        cnt_d    = '0;
        clk_on_d = 1'b1;
      end
    endcase
  end

  // en is derived from the next clk_on so that both flops update on the
  // same edge and en never depends combinationally on an input.
  assign en_d = ACTIVE_VALUE ? ~clk_on_d : clk_on_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q  <= CG_ON;
      cnt_q    <= '0;
      clk_on_q <= 1'b1;
      ack_q    <= 1'b0;
      en_q     <= ~ACTIVE_VALUE;
      gated_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_on_q <= clk_on_d;
      ack_q    <= ack_d;
      en_q     <= en_d;
      gated_q  <= gated_d;
    end
  end

  assign en           = en_q;
  assign clk_on       = clk_on_q;
  assign ack          = ack_q;
  assign gated_cycles = gated_q;

endmodule

// File: tb/tb_cg_enable_ctrl.sv
// Self-checking bench for cg_enable_ctrl.
// dut_a: defaults (IDLE 16, WAKE 2, ACTIVE_VALUE 0, STAT_W 16).
// dut_b: IDLE 4, WAKE 2, ACTIVE_VALUE 1, STAT_W 4 (polarity and saturation).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns after the
// following rising edge, so each step() shows the result of the inputs that
// were applied during the cycle just ended.
module tb_cg_enable_ctrl;

  logic clk_in = 1'b0;
  logic rst;

  logic        busy_a, req_a, force_a;
  logic        a_en, a_clk_on, a_ack;
  logic [15:0] a_gated;

  logic        busy_b, req_b, force_b;
  logic        b_en, b_clk_on, b_ack;
  logic [3:0]  b_gated;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  cg_enable_ctrl #(
    .IDLE_CYCLES (16),
    .WAKE_CYCLES (2),
    .CNT_W       (8),
    .ACTIVE_VALUE(1'b0),
    .STAT_W      (16)
  ) dut_a (
    .clk_in      (clk_in),
    .rst         (rst),
    .busy        (busy_a),
    .req         (req_a),
    .force_on    (force_a),
    .en          (a_en),
    .clk_on      (a_clk_on),
    .ack         (a_ack),
    .gated_cycles(a_gated)
  );

  cg_enable_ctrl #(
    .IDLE_CYCLES (4),
    .WAKE_CYCLES (2),
    .CNT_W       (8),
    .ACTIVE_VALUE(1'b1),
    .STAT_W      (4)
  ) dut_b (
    .clk_in      (clk_in),
    .rst         (rst),
    .busy        (busy_b),
    .req         (req_b),
    .force_on    (force_b),
    .en          (b_en),
    .clk_on      (b_clk_on),
    .ack         (b_ack),
    .gated_cycles(b_gated)
  );

  typedef struct {
    logic busy;
    logic req;
    logic force_on;
    logic exp_clk_on;
    logic exp_ack;
    logic exp_en;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    busy_a = 1'b0; req_a = 1'b0; force_a = 1'b0;
    busy_b = 1'b0; req_b = 1'b0; force_b = 1'b0;

    // ON-state behaviour from a fresh reset: activity, one ack per request,
    // req+force_on acts like req, force_on alone never acks.
    //          busy  req   force exp_clk_on exp_ack exp_en
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // ---- Reset, both polarities ----
    step();
    step();
    check("rst_a_clk_on", 32'(a_clk_on), 1);
    check("rst_a_en",     32'(a_en),     1);
    check("rst_a_ack",    32'(a_ack),    0);
    check("rst_a_gated",  32'(a_gated),  0);
    check("rst_b_clk_on", 32'(b_clk_on), 1);
    check("rst_b_en",     32'(b_en),     0);
    check("rst_b_gated",  32'(b_gated),  0);

    // ---- dut_b: gating after 4 idle cycles, inverted en, saturation ----
    rst = 1'b0;
    repeat (3) step();
    check("b_pregate_clk_on", 32'(b_clk_on), 1);
    check("b_pregate_en",     32'(b_en),     0);
    step();
    check("b_gate_clk_on", 32'(b_clk_on), 0);
    check("b_gate_en",     32'(b_en),     1);
    check("b_gate_gated",  32'(b_gated),  0);
    for (int i = 1; i <= 20; i++) begin
      step();
      check("b_sat_gated", 32'(b_gated), (i > 15) ? 15 : i);
    end

    // ---- dut_a: fresh reset, then table of ON-state vectors ----
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      busy_a  = vecs[i].busy;
      req_a   = vecs[i].req;
      force_a = vecs[i].force_on;
      step();
      check("vec_clk_on", 32'(a_clk_on), 32'(vecs[i].exp_clk_on));
      check("vec_ack",    32'(a_ack),    32'(vecs[i].exp_ack));
      check("vec_en",     32'(a_en),     32'(vecs[i].exp_en));
    end
    force_a = 1'b0;

    // ---- Activity on the final idle cycle restarts the count ----
    busy_a = 1'b1;
    step();
    busy_a = 1'b0;
    repeat (15) step();
    check("idle15_clk_on", 32'(a_clk_on), 1);
    busy_a = 1'b1;
    step();
    check("last_idle_busy_clk_on", 32'(a_clk_on), 1);
    busy_a = 1'b0;
    repeat (15) step();
    check("restart_idle15_clk_on", 32'(a_clk_on), 1);
    step();
    check("gate_clk_on", 32'(a_clk_on), 0);
    check("gate_en",     32'(a_en),     0);
    check("gate_gated",  32'(a_gated),  0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("off_gated", 32'(a_gated), i);
    end

    // busy is ignored while gated
    busy_a = 1'b1;
    step();
    check("off_busy_clk_on", 32'(a_clk_on), 0);
    check("off_busy_gated",  32'(a_gated),  4);
    busy_a = 1'b0;

    // ---- Wake on req: clk_on at M+1, ack only at M+3 ----
    req_a = 1'b1;
    step();
    check("wake1_clk_on", 32'(a_clk_on), 1);
    check("wake1_en",     32'(a_en),     1);
    check("wake1_ack",    32'(a_ack),    0);
    step();
    check("wake2_ack", 32'(a_ack), 0);
    step();
    check("wake_ack",    32'(a_ack),    1);
    check("wake_clk_on", 32'(a_clk_on), 1);
    step();
    check("wake_no_second_ack", 32'(a_ack), 0);
    req_a = 1'b0;
    step();
    check("wake_after_drop_ack", 32'(a_ack),   0);
    check("wake_gated_frozen",   32'(a_gated), 5);

    // ---- force_on: wake without ack, hold on regardless of busy ----
    repeat (16) step();
    check("regate_clk_on", 32'(a_clk_on), 0);
    force_a = 1'b1;
    step();
    check("force_wake_clk_on", 32'(a_clk_on), 1);
    for (int i = 0; i < 20; i++) begin
      busy_a = (i % 2 == 1);
      step();
      check("force_hold_clk_on", 32'(a_clk_on), 1);
      check("force_hold_ack",    32'(a_ack),    0);
    end
    force_a = 1'b0;
    busy_a  = 1'b0;
    repeat (15) step();
    check("force_rel_idle15_clk_on", 32'(a_clk_on), 1);
    step();
    check("force_rel_gate_clk_on", 32'(a_clk_on), 0);

    // ---- Reset in WAKE discards the pending ack ----
    req_a = 1'b1;
    step();
    check("rstwake_clk_on", 32'(a_clk_on), 1);
    step();
    check("rstwake_pre_ack", 32'(a_ack), 0);
    rst = 1'b1;
    step();
    check("rstwake_ack",    32'(a_ack),    0);
    check("rstwake_clk_on", 32'(a_clk_on), 1);
    check("rstwake_en",     32'(a_en),     1);
    check("rstwake_gated",  32'(a_gated),  0);
    rst   = 1'b0;
    req_a = 1'b0;
    step();
    check("post_rst_ack",    32'(a_ack),    0);
    check("post_rst_clk_on", 32'(a_clk_on), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
